conv_result_writer: RTL and testbench
=====================================

# conv_result_writer

Receive-side counterpart to the pixel stream feeding FilterTop: captures FilterTop's output pixel stream (`io_pixel_o`/`io_output_valid`/`io_image_finished`) and writes it into a frame buffer instead of a file. Packs PACK pixels per memory word, writes sequential addresses from 0, zero-pads the final partial word, reports the pixel count and flags overflow. Sits between FilterTop and the result BRAM read by the PS.

## Interface
- PIX_W, 8, pixel width (matches `io_pixel_o`)
- PACK, 4, pixels per memory word; power of two, ≥2
- ADDR_W, 12, word address width; capacity = 2^ADDR_W words
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; `reset`=0 clears all state immediately
- io_start  in  1  arm capture of a new frame; sampled only in IDLE
- io_pixel_i  in  PIX_W  pixel from FilterTop `io_pixel_o`
- io_pixel_valid  in  1  from FilterTop `io_output_valid`; qualifies io_pixel_i
- io_image_finished  in  1  end-of-frame from FilterTop; single-cycle pulse
- io_busy  out  1  high from the cycle after accepted io_start until io_done cycle
- io_wr_en  out  1  one-cycle memory write strobe
- io_wr_addr  out  ADDR_W  word address
- io_wr_data  out  PIX_W*PACK  packed word; lane k at bits [k*PIX_W +: PIX_W]
- io_done  out  1  one-cycle pulse, frame committed
- io_pix_count  out  ADDR_W+log2(PACK)+1  pixels accepted this frame
- io_overflow  out  1  sticky; pixels dropped for lack of capacity

## Operation
- All outputs registered; reset value 0 for every output, state IDLE, lane index 0, address 0.
- States: IDLE, CAPTURE, DONE.
- IDLE: io_start=1 → CAPTURE; clear lane index, address, io_pix_count, io_overflow. io_pixel_valid, io_image_finished ignored.
- CAPTURE: each valid pixel stored in lane = lane index, lane index increments mod PACK, io_pix_count +1.
  - Lane PACK-1 filled → write full word next cycle at current address; address +1 after the write.
  - io_image_finished=1 → DONE. A valid pixel in the same cycle is captured first. If lane index (after that pixel) ≠0, the partial word is written next cycle with unused lanes = 0.
  - io_start ignored.
- DONE: io_done=1 for one cycle, io_busy=0, → IDLE. io_pix_count and io_overflow hold until next accepted io_start.
- Capacity: once 2^ADDR_W words are written, further valid pixels are dropped (not counted, no write); io_overflow=1. Address never wraps.
- Empty frame (io_image_finished with no pixels): no write, io_done still pulses, count 0.
- reset low mid-frame: partial word discarded, no write, no io_done.

## Timing
- Pixel completing a word at cycle t → io_wr_en, io_wr_addr, io_wr_data valid at t+1 only.
- io_image_finished at cycle t → final (full or partial) write at t+1 if any; io_done at t+1 and io_busy low at t+1. io_done and a final write may share a cycle.
- Back-to-back valid pixels sustained indefinitely: one write every PACK cycles, no stall. No backpressure to FilterTop.
- io_start at t in IDLE → io_busy at t+1, first pixel accepted at t+1.

## Structure
- Shared package `conv_io_pkg`: PIX_W, PACK defaults, state enum `wr_state_e` {IDLE, CAPTURE, DONE}, shared with the input-side streamer.
- One sub-module: `pix_packer` (lane shift/assemble register, lane index, word-complete flag, zero-pad on flush). FSM, address, count and overflow stay in the top.

## Test plan
- Reset: hold `reset`=0 with io_start=1 → all outputs 0; release, io_start pulse → io_busy=1 next cycle.
- Full words: start, 8 consecutive pixels 0x01..0x08, then io_image_finished → writes {addr 0, 0x04030201}, {addr 1, 0x08070605}; io_done; io_pix_count=8.
- Partial flush: 6 pixels 0xA0..0xA5, io_image_finished coincident with 0xA5 → addr 1 data 0x0000A5A4 one cycle later, io_done same cycle, count=6.
- Gapped valid: pixels on every third cycle, 4 total → single write at addr 0 exactly one cycle after 4th pixel.
- Overflow with ADDR_W=2: 20 pixels → 4 writes (addr 0..3), io_overflow=1, io_pix_count=16, no write at addr 0 again.
- Mid-frame reset after 3 pixels → no io_wr_en, no io_done; next frame starts at addr 0, count 0.

Source files
------------

// File: rtl/conv_io_pkg.sv
// Shared definitions for the FilterTop pixel-stream adapters (input streamer
// and result writer).
package conv_io_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int PACK_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } wr_state_e;

endpackage

// File: rtl/pix_packer.sv
// Lane assembler: gathers pixels into a PACK-lane word and presents a full
// word, or a zero-padded partial word on flush, combinationally to the writer.
module pix_packer
    import conv_io_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int PACK  = PACK_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  flush,
    input  logic [PIX_W-1:0]      pixel,
    output logic [PIX_W*PACK-1:0] word,
    output logic                  word_valid
);

    localparam int LANE_W = $clog2(PACK);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [LANE_W-1:0] LANE_ZERO = LANE_W'(0);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);

    logic [PIX_W*PACK-1:0] lanes_r;
    logic [LANE_W-1:0]     idx_r;
    logic [LANE_W-1:0]     idx_next_s;
    logic [PIX_W*PACK-1:0] word_s;
    logic                  word_valid_s;

    // Merge the incoming pixel into its lane; lanes above it are still zero
    always_comb begin
        word_s = lanes_r;
        for (int k = 0; k < PACK; k++) begin
            if (push && (idx_r == LANE_W'(k))) begin
                word_s[k*PIX_W +: PIX_W] = pixel;
            end else begin
                word_s[k*PIX_W +: PIX_W] = lanes_r[k*PIX_W +: PIX_W];
            end
        end
    end

    // Lane index advance and word-emit decision (full word, or non-empty flush)
    always_comb begin
        idx_next_s   = idx_r;
        word_valid_s = 1'b0;
        if (push) begin
            idx_next_s = idx_r + LANE_ONE;
        end else begin
            idx_next_s = idx_r;
        end
        if (push && (idx_r == LANE_LAST)) begin
            word_valid_s = 1'b1;
        end else if (flush && (idx_next_s != LANE_ZERO)) begin
            word_valid_s = 1'b1;
        end else begin
            word_valid_s = 1'b0;
        end
    end

    // Lane storage; emptied after every emitted word so padding is implicit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes_r <= '0;
            idx_r   <= LANE_ZERO;
        end else if (clear || flush || word_valid_s) begin
            lanes_r <= '0;
            idx_r   <= LANE_ZERO;
        end else if (push) begin
            lanes_r <= word_s;
            idx_r   <= idx_next_s;
        end else begin
            lanes_r <= lanes_r;
            idx_r   <= idx_r;
        end
    end

    assign word       = word_s;
    assign word_valid = word_valid_s;

endmodule

// File: rtl/conv_result_writer.sv
// Captures FilterTop's output pixel stream and writes it, PACK pixels per
// word, into the result frame buffer from address 0.
module conv_result_writer
    import conv_io_pkg::*;
#(
    parameter int  PIX_W  = PIX_W_DEF,
    parameter int  PACK   = PACK_DEF,
    parameter int  ADDR_W = 12,
    localparam int CNT_W  = ADDR_W + $clog2(PACK) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_start,
    input  logic [PIX_W-1:0]      io_pixel_i,
    input  logic                  io_pixel_valid,
    input  logic                  io_image_finished,
    output logic                  io_busy,
    output logic                  io_wr_en,
    output logic [ADDR_W-1:0]     io_wr_addr,
    output logic [PIX_W*PACK-1:0] io_wr_data,
    output logic                  io_done,
    output logic [CNT_W-1:0]      io_pix_count,
    output logic                  io_overflow
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    wr_state_e             state_r;
    wr_state_e             state_next_s;
    logic [ADDR_W-1:0]     addr_r;
    logic                  full_r;
    logic                  clear_s;
    logic                  accept_s;
    logic                  drop_s;
    logic                  flush_s;
    logic [PIX_W*PACK-1:0] word_s;
    logic                  word_valid_s;

    pix_packer #(
        .PIX_W (PIX_W),
        .PACK  (PACK)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_s),
        .push       (accept_s),
        .flush      (flush_s),
        .pixel      (io_pixel_i),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Frame FSM: next state and per-cycle control strobes
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        accept_s     = 1'b0;
        drop_s       = 1'b0;
        flush_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (io_start) begin
                    clear_s      = 1'b1;
                    state_next_s = CAPTURE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CAPTURE: begin
                accept_s = io_pixel_valid && !full_r;
                drop_s   = io_pixel_valid && full_r;
                if (io_image_finished) begin
                    flush_s      = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = CAPTURE;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Write port, address/capacity tracking and frame status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_busy      <= 1'b0;
            io_wr_en     <= 1'b0;
            io_wr_addr   <= '0;
            io_wr_data   <= '0;
            io_done      <= 1'b0;
            io_pix_count <= '0;
            io_overflow  <= 1'b0;
            addr_r       <= '0;
            full_r       <= 1'b0;
        end else begin
            io_wr_en <= word_valid_s;
            io_done  <= flush_s;
            if (word_valid_s) begin
                io_wr_addr <= addr_r;
                io_wr_data <= word_s;
            end else begin
                io_wr_addr <= io_wr_addr;
                io_wr_data <= io_wr_data;
            end
            if (clear_s) begin
                io_busy <= 1'b1;
            end else if (flush_s) begin
                io_busy <= 1'b0;
            end else begin
                io_busy <= io_busy;
            end
            if (clear_s) begin
                addr_r       <= '0;
                full_r       <= 1'b0;
                io_pix_count <= '0;
                io_overflow  <= 1'b0;
            end else begin
                // The last address is written once; afterwards the buffer is full
                if (word_valid_s && (addr_r == ADDR_MAX)) begin
                    full_r <= 1'b1;
                    addr_r <= addr_r;
                end else if (word_valid_s) begin
                    full_r <= full_r;
                    addr_r <= addr_r + ADDR_ONE;
                end else begin
                    full_r <= full_r;
                    addr_r <= addr_r;
                end
                if (accept_s) begin
                    io_pix_count <= io_pix_count + CNT_ONE;
                end else begin
                    io_pix_count <= io_pix_count;
                end
                if (drop_s) begin
                    io_overflow <= 1'b1;
                end else begin
                    io_overflow <= io_overflow;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_result_writer.sv
// Scoreboard bench for conv_result_writer: a default instance (ADDR_W=12) and
// a small one (ADDR_W=2) for capacity/overflow behaviour.
module tb_conv_result_writer;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_exp_t;

    typedef struct {
        int   count;
        logic ovf;
        int   cyc;
    } done_exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    logic        a_start, a_valid, a_fin;
    logic [7:0]  a_pix;
    logic        a_busy, a_wr_en, a_done, a_ovf;
    logic [11:0] a_wr_addr;
    logic [31:0] a_wr_data;
    logic [14:0] a_count;

    logic        b_start, b_valid, b_fin;
    logic [7:0]  b_pix;
    logic        b_busy, b_wr_en, b_done, b_ovf;
    logic [1:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [4:0]  b_count;

    wr_exp_t   wq0[$];
    wr_exp_t   wq1[$];
    done_exp_t dq0[$];
    done_exp_t dq1[$];

    conv_result_writer #(.PIX_W(8), .PACK(4), .ADDR_W(12)) dut_a (
        .clk(clk), .reset(reset), .io_start(a_start), .io_pixel_i(a_pix),
        .io_pixel_valid(a_valid), .io_image_finished(a_fin), .io_busy(a_busy),
        .io_wr_en(a_wr_en), .io_wr_addr(a_wr_addr), .io_wr_data(a_wr_data),
        .io_done(a_done), .io_pix_count(a_count), .io_overflow(a_ovf)
    );

    conv_result_writer #(.PIX_W(8), .PACK(4), .ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .io_start(b_start), .io_pixel_i(b_pix),
        .io_pixel_valid(b_valid), .io_image_finished(b_fin), .io_busy(b_busy),
        .io_wr_en(b_wr_en), .io_wr_addr(b_wr_addr), .io_wr_data(b_wr_data),
        .io_done(b_done), .io_pix_count(b_count), .io_overflow(b_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare one instance's write/done activity against its queues
    task automatic mon_inst(input int i, input logic wr_en, input int addr, input logic [31:0] data,
                            input logic done, input int count, input logic ovf, input logic busy);
        wr_exp_t   we;
        done_exp_t de;
        bit        empty;
        if (wr_en === 1'b1) begin
            empty = (i == 0) ? (wq0.size() == 0) : (wq1.size() == 0);
            if (empty) begin
                chk($sformatf("unexpected_write_%0d", i), 64'(addr), 64'hFFFF_FFFF);
            end else begin
                if (i == 0) we = wq0.pop_front(); else we = wq1.pop_front();
                chk($sformatf("wr_addr_%0d", i), 64'(addr), 64'(we.addr));
                chk($sformatf("wr_data_%0d", i), 64'(data), 64'(we.data));
                chk($sformatf("wr_cycle_%0d", i), 64'(cyc), 64'(we.cyc));
            end
        end
        if (done === 1'b1) begin
            empty = (i == 0) ? (dq0.size() == 0) : (dq1.size() == 0);
            if (empty) begin
                chk($sformatf("unexpected_done_%0d", i), 64'(count), 64'hFFFF_FFFF);
            end else begin
                if (i == 0) de = dq0.pop_front(); else de = dq1.pop_front();
                chk($sformatf("done_count_%0d", i), 64'(count), 64'(de.count));
                chk($sformatf("done_overflow_%0d", i), 64'(ovf), 64'(de.ovf));
                chk($sformatf("done_busy_low_%0d", i), 64'(busy), 64'd0);
                chk($sformatf("done_cycle_%0d", i), 64'(cyc), 64'(de.cyc));
            end
        end
    endtask

    always @(negedge clk) begin
        mon_inst(0, a_wr_en, int'(a_wr_addr), a_wr_data, a_done, int'(a_count), a_ovf, a_busy);
        mon_inst(1, b_wr_en, int'(b_wr_addr), b_wr_data, b_done, int'(b_count), b_ovf, b_busy);
    end

    // One stimulus cycle for instance i; the other instance is held idle
    task automatic drv(input int i, input logic st, input logic v, input int p, input logic f);
        @(posedge clk);
        #1;
        a_start = 1'b0; a_valid = 1'b0; a_pix = 8'h00; a_fin = 1'b0;
        b_start = 1'b0; b_valid = 1'b0; b_pix = 8'h00; b_fin = 1'b0;
        if (i == 0) begin
            a_start = st; a_valid = v; a_pix = 8'(p); a_fin = f;
        end else begin
            b_start = st; b_valid = v; b_pix = 8'(p); b_fin = f;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drv(0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic exp_wr(input int i, input int addr, input logic [31:0] data);
        wr_exp_t e;
        e.addr = addr; e.data = data; e.cyc = cyc + 1;
        if (i == 0) wq0.push_back(e); else wq1.push_back(e);
    endtask

    task automatic exp_done(input int i, input int count, input logic ovf);
        done_exp_t e;
        e.count = count; e.ovf = ovf; e.cyc = cyc + 1;
        if (i == 0) dq0.push_back(e); else dq1.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        a_start = 1'b1; a_valid = 1'b0; a_pix = 8'h00; a_fin = 1'b0;
        b_start = 1'b1; b_valid = 1'b0; b_pix = 8'h00; b_fin = 1'b0;

        // Reset held with io_start asserted: every output stays 0
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_wr_en", 64'(a_wr_en), 64'd0);
        chk("rst_wr_addr", 64'(a_wr_addr), 64'd0);
        chk("rst_wr_data", 64'(a_wr_data), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_overflow", 64'(a_ovf), 64'd0);
        chk("rst_b_busy", 64'(b_busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        a_start = 1'b0;
        b_start = 1'b0;
        idle(2);

        // Two full words
        drv(0, 1'b1, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            drv(0, 1'b0, 1'b1, k, 1'b0);
            if (k == 1) chk("start_busy", 64'(a_busy), 64'd1);
            if (k == 4) exp_wr(0, 0, 32'h0403_0201);
            if (k == 8) exp_wr(0, 1, 32'h0807_0605);
        end
        drv(0, 1'b0, 1'b0, 0, 1'b1);
        exp_done(0, 8, 1'b0);
        idle(3);
        chk("count_hold", 64'(a_count), 64'd8);
        chk("busy_after_done", 64'(a_busy), 64'd0);

        // Partial flush coincident with the last pixel
        drv(0, 1'b1, 1'b0, 0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drv(0, 1'b0, 1'b1, 8'hA0 + k, 1'b0);
            if (k == 3) exp_wr(0, 0, 32'hA3A2_A1A0);
        end
        drv(0, 1'b0, 1'b1, 8'hA5, 1'b1);
        exp_wr(0, 1, 32'h0000_A5A4);
        exp_done(0, 6, 1'b0);
        idle(3);

        // Gapped valid: one pixel every third cycle
        drv(0, 1'b1, 1'b0, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drv(0, 1'b0, 1'b1, 8'h11 * (k + 1), 1'b0);
            if (k == 3) exp_wr(0, 0, 32'h4433_2211);
            idle(2);
        end
        drv(0, 1'b0, 1'b0, 0, 1'b1);
        exp_done(0, 4, 1'b0);
        idle(3);

        // Empty frame
        drv(0, 1'b1, 1'b0, 0, 1'b0);
        drv(0, 1'b0, 1'b0, 0, 1'b1);
        exp_done(0, 0, 1'b0);
        idle(3);

        // Overflow on the 4-word instance
        drv(1, 1'b1, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            drv(1, 1'b0, 1'b1, k, 1'b0);
            if (k == 4)  exp_wr(1, 0, 32'h0403_0201);
            if (k == 8)  exp_wr(1, 1, 32'h0807_0605);
            if (k == 12) exp_wr(1, 2, 32'h0C0B_0A09);
            if (k == 16) exp_wr(1, 3, 32'h100F_0E0D);
        end
        drv(1, 1'b0, 1'b0, 0, 1'b1);
        exp_done(1, 16, 1'b1);
        idle(3);
        chk("ovf_sticky", 64'(b_ovf), 64'd1);
        chk("ovf_count_hold", 64'(b_count), 64'd16);
        drv(1, 1'b1, 1'b0, 0, 1'b0);
        idle(1);
        chk("restart_ovf_clear", 64'(b_ovf), 64'd0);
        chk("restart_count_clear", 64'(b_count), 64'd0);
        chk("restart_busy", 64'(b_busy), 64'd1);
        drv(1, 1'b0, 1'b1, 8'h5A, 1'b1);
        exp_wr(1, 0, 32'h0000_005A);
        exp_done(1, 1, 1'b0);
        idle(3);

        // Mid-frame reset after 3 pixels: nothing written, no done
        drv(0, 1'b1, 1'b0, 0, 1'b0);
        drv(0, 1'b0, 1'b1, 8'h55, 1'b0);
        drv(0, 1'b0, 1'b1, 8'h66, 1'b0);
        drv(0, 1'b0, 1'b1, 8'h77, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", 64'(a_busy), 64'd0);
        chk("midrst_count", 64'(a_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);
        drv(0, 1'b1, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            drv(0, 1'b0, 1'b1, k, 1'b0);
            if (k == 1) chk("after_rst_count", 64'(a_count), 64'd0);
            if (k == 4) exp_wr(0, 0, 32'h0403_0201);
        end
        drv(0, 1'b0, 1'b0, 0, 1'b1);
        exp_done(0, 4, 1'b0);
        idle(5);

        chk("pending_writes_a", 64'(wq0.size()), 64'd0);
        chk("pending_writes_b", 64'(wq1.size()), 64'd0);
        chk("pending_done_a", 64'(dq0.size()), 64'd0);
        chk("pending_done_b", 64'(dq1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
